// File: rtl/mdu_iter.sv
// Iterative-latency MIPS multiply/divide unit owning HI/LO; the result is computed at issue
// and committed after a fixed busy period. Optional MDU_CANCEL_EN adds an abort input.
module mdu_iter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_wr;
  logic        kill;

`ifdef MDU_CANCEL_EN
  assign kill = cancel;
`else
  assign kill = 1'b0;
`endif

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] sa, sb, sb_safe, sq, sr;
  logic        [31:0] ub_safe, uq, ur;
  logic               div_zero, div_ovf;

  // Zero divisors and the signed overflow case divide by 1 instead: overflow then
  // yields exactly 0x80000000 / 0, and a zero divisor's result is never committed.
  always_comb begin
    sa       = $signed(rs_val);
    sb       = $signed(rt_val);
    prod_s   = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    prod_u   = {32'd0, rs_val} * {32'd0, rt_val};
    div_zero = (rt_val == 32'd0);
    div_ovf  = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
    sb_safe  = (div_zero || div_ovf) ? 32'sd1 : sb;
    ub_safe  = div_zero ? 32'd1 : rt_val;
    sq       = sa / sb_safe;
    sr       = sa % sb_safe;
    uq       = rs_val / ub_safe;
    ur       = rs_val % ub_safe;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !kill) begin
            case (mdu_op)
              OP_MULT: begin
                pend_hi <= prod_s[63:32];
                pend_lo <= prod_s[31:0];
                pend_wr <= 1'b1;
                cnt     <= 4'(MULT_CYCLES);
                busy    <= 1'b1;
                state   <= RUN;
              end
              OP_MULTU: begin
                pend_hi <= prod_u[63:32];
                pend_lo <= prod_u[31:0];
                pend_wr <= 1'b1;
                cnt     <= 4'(MULT_CYCLES);
                busy    <= 1'b1;
                state   <= RUN;
              end
              OP_DIV: begin
                pend_hi <= sr;
                pend_lo <= sq;
                pend_wr <= !div_zero;
                cnt     <= 4'(DIV_CYCLES);
                busy    <= 1'b1;
                state   <= RUN;
              end
              OP_DIVU: begin
                pend_hi <= ur;
                pend_lo <= uq;
                pend_wr <= !div_zero;
                cnt     <= 4'(DIV_CYCLES);
                busy    <= 1'b1;
                state   <= RUN;
              end
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (kill) begin
            busy    <= 1'b0;
            pend_wr <= 1'b0;
            cnt     <= 4'd0;
            state   <= IDLE;
          end else if (cnt == 4'd1) begin
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            pend_wr <= 1'b0;
            busy    <= 1'b0;
            cnt     <= 4'd0;
            state   <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: the driver pushes {busy_len, hi, lo} per operation and a
// negedge monitor pops and compares whenever an operation completes.
module tb_mdu_iter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic        cancel;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_iter #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdu_op (mdu_op),
`ifdef MDU_CANCEL_EN
    .cancel (cancel),
`endif
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [71:0] exp_q[$];
  logic        chk_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_res(input logic [7:0] len, input logic [31:0] e_hi, input logic [31:0] e_lo);
    exp_q.push_back({len, e_hi, e_lo});
  endtask

  // Caller is at posedge+1; start is sampled at the next rising edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic do_chk);
    start  = 1'b1;
    mdu_op = op;
    rs_val = a;
    rt_val = b;
    @(posedge clk); #1;
    start   = 1'b0;
    mdu_op  = 3'b000;
    chk_req = do_chk;
    if (do_chk) begin
      @(posedge clk); #1;
      chk_req = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) return;
      @(posedge clk); #1;
    end
    n_cmp++;
    n_err++;
    $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", busy, budget);
  endtask

  // scoreboard monitor
  logic        busy_prev = 1'b0;
  logic [7:0]  busy_cnt = 8'd0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;
  logic [71:0] e;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        model_hi  = 32'd0;
        model_lo  = 32'd0;
        busy_prev = 1'b0;
        busy_cnt  = 8'd0;
      end else begin
        if (busy) begin
          busy_cnt++;
          chk("hold_hi", hi, model_hi);
          chk("hold_lo", lo, model_lo);
        end
        if ((busy_prev && !busy) || chk_req) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_completion: busy_len %0d hi %08h lo %08h, required none",
                     busy_cnt, hi, lo);
          end else begin
            e = exp_q.pop_front();
            chk("busy_len", {24'd0, busy_cnt}, {24'd0, e[71:64]});
            chk("res_hi", hi, e[63:32]);
            chk("res_lo", lo, e[31:0]);
            model_hi = e[63:32];
            model_lo = e[31:0];
          end
          busy_cnt = 8'd0;
        end
        busy_prev = busy;
      end
    end
  end

  // driver
  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    mdu_op = 3'b000;
    cancel = 1'b0;
    rs_val = 32'd0;
    rt_val = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // signed mult latency
    expect_res(8'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    issue(3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    wait_idle(40);

    // unsigned forms, issued back to back
    expect_res(8'd5, 32'h0000_0001, 32'hFFFF_FFFE);
    issue(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    wait_idle(40);
    expect_res(8'd10, 32'h0000_0001, 32'h7FFF_FFFC);
    issue(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    wait_idle(40);

    // signed divide and overflow
    expect_res(8'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    wait_idle(40);
    expect_res(8'd10, 32'h0000_0000, 32'h8000_0000);
    issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(40);

    // none/reserved ops leave state alone
    expect_res(8'd0, 32'h0000_0000, 32'h8000_0000);
    issue(3'b000, 32'h1111_1111, 32'h2222_2222, 1'b1);
    expect_res(8'd0, 32'h0000_0000, 32'h8000_0000);
    issue(3'b111, 32'h3333_3333, 32'h4444_4444, 1'b1);

    // mthi/mtlo preload, divide by zero, mid-run start ignored
    expect_res(8'd0, 32'hAAAA_0000, 32'h8000_0000);
    issue(3'b101, 32'hAAAA_0000, 32'h0, 1'b1);
    expect_res(8'd0, 32'hAAAA_0000, 32'h0000_BBBB);
    issue(3'b110, 32'h0000_BBBB, 32'h0, 1'b1);
    expect_res(8'd10, 32'hAAAA_0000, 32'h0000_BBBB);
    issue(3'b011, 32'h0000_1234, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    issue(3'b001, 32'h0000_0005, 32'h0000_0005, 1'b0);
    issue(3'b101, 32'hDEAD_BEEF, 32'h0, 1'b0);
    wait_idle(40);
    repeat (12) @(posedge clk);
    #1;

`ifdef MDU_CANCEL_EN
    // cancel on the 3rd busy cycle, then an immediate mult
    issue(3'b011, 32'd100, 32'd7, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    cancel = 1'b1;
    expect_res(8'd3, 32'hAAAA_0000, 32'h0000_BBBB);
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    expect_res(8'd5, 32'h0000_0000, 32'h0000_002A);
    issue(3'b001, 32'd7, 32'd6, 1'b0);
    wait_idle(40);
    // cancel together with start in IDLE suppresses mthi
    cancel = 1'b1;
    expect_res(8'd0, 32'h0000_0000, 32'h0000_002A);
    issue(3'b101, 32'h5555_5555, 32'h0, 1'b1);
    cancel = 1'b0;
`endif

    // reset mid-div with counter at 4
    issue(3'b011, 32'd9, 32'd3, 1'b0);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_busy", {31'd0, busy}, 32'd0);
    chk("async_reset_hi", hi, 32'd0);
    chk("async_reset_lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    expect_res(8'd0, 32'h1234_5678, 32'h0000_0000);
    issue(3'b101, 32'h1234_5678, 32'h0, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drain", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
